// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - coin codes, channel indices and default sizing for the coin acceptor
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE     = 2'b00,
    COIN_PENNY    = 2'b01,
    COIN_HAPENNY  = 2'b10,
    COIN_FARTHING = 2'b11
  } coin_t;

  localparam int CH_PENNY    = 0;
  localparam int CH_HAPENNY  = 1;
  localparam int CH_FARTHING = 2;

  localparam int DEB_CYCLES_DEF = 500000;
  localparam int DEPTH_DEF      = 4;

  function automatic logic f_multi(input logic [2:0] presses);
    return (presses[0] & presses[1]) | (presses[0] & presses[2]) | (presses[1] & presses[2]);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - 2-flop synchroniser, counter debouncer and registered press-edge pulse
module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk50m,
  input  logic res,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;

  always_ff @(posedge clk50m) begin
    if (res) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // any sample matching the current level restarts the stability window
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin buttons queued in a fall-through FIFO with valid/ready output
// Optional build macro COIN_MULTI_REJECT_EN: reject simultaneous multi-coin presses instead of prioritising.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                     clk50m,
  input  logic                     res,
  input  logic [2:0]               coin_raw,
  input  logic                     coin_ready,
  output logic                     coin_valid,
  output logic [1:0]               coin_code,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     reject
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [2:0]    w_level;
  logic [2:0]    w_press;
  logic          w_unused_level;
  logic          w_push_req;
  coin_t         w_push_code;
  logic          w_multi;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_reject;

  for (genvar g = 0; g < 3; g++) begin : g_deb
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk50m (clk50m),
      .res    (res),
      .raw    (coin_raw[g]),
      .level  (w_level[g]),
      .press  (w_press[g])
    );
  end

  assign w_unused_level = ^w_level;

  always_comb begin
    w_push_req  = 1'b0;
    w_push_code = COIN_NONE;
    w_multi     = 1'b0;
`ifdef COIN_MULTI_REJECT_EN
    if (f_multi(w_press)) begin
      w_multi = 1'b1;
    end else if (|w_press) begin
      w_push_req  = 1'b1;
      w_push_code = w_press[CH_PENNY]   ? COIN_PENNY :
                    w_press[CH_HAPENNY] ? COIN_HAPENNY : COIN_FARTHING;
    end
`else
    if (w_press[CH_PENNY]) begin
      w_push_req  = 1'b1;
      w_push_code = COIN_PENNY;
    end else if (w_press[CH_HAPENNY]) begin
      w_push_req  = 1'b1;
      w_push_code = COIN_HAPENNY;
    end else if (w_press[CH_FARTHING]) begin
      w_push_req  = 1'b1;
      w_push_code = COIN_FARTHING;
    end
`endif
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == C_FULL);
  assign w_pop   = w_valid & coin_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push  = w_push_req & (~w_full | w_pop);

  always_ff @(posedge clk50m) begin
    if (res) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_reject <= w_multi;
      if (w_push_req & w_full & ~w_pop) r_overflow <= 1'b1;
      if (w_push) begin
        r_mem[r_wptr] <= w_push_code;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign coin_valid = w_valid;
  assign coin_code  = w_valid ? r_mem[r_rptr] : 2'b00;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
`ifdef COIN_MULTI_REJECT_EN
  assign reject     = r_reject;
`else
  assign reject     = 1'b0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor with DEB_CYCLES=4, DEPTH=4
`timescale 1ns/1ps
module tb_coin_acceptor;

  logic       clk50m = 1'b0;
  logic       res;
  logic [2:0] coin_raw;
  logic       coin_ready;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       reject;

  int n_tests = 0;
  int n_fail  = 0;

  coin_acceptor #(.DEB_CYCLES(4), .DEPTH(4)) dut (
    .clk50m     (clk50m),
    .res        (res),
    .coin_raw   (coin_raw),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_code  (coin_code),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .reject     (reject)
  );

  always #10 clk50m = ~clk50m;

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    res = 1'b1;
    coin_raw = 3'b000;
    coin_ready = 1'b0;
    tick();
    tick();
    res = 1'b0;
  endtask

  task automatic press_coin(input int ch);
    coin_raw[ch] = 1'b1;
    repeat (10) tick();
    coin_raw[ch] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int rej_seen;
    logic [1:0] exp_codes [4];

    do_reset();
    check("reset_valid", coin_valid, 0);
    check("reset_code", coin_code, 0);
    check("reset_count", fifo_count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_reject", reject, 0);

    // single penny: valid exactly 8 edges after the raw edge
    coin_raw[0] = 1'b1;
    repeat (7) tick();
    check("penny_valid_edge7", coin_valid, 0);
    tick();
    check("penny_valid_edge8", coin_valid, 1);
    check("penny_code", coin_code, 2'b01);
    check("penny_count", fifo_count, 1);
    tick();
    tick();
    coin_raw[0] = 1'b0;
    repeat (12) tick();
    check("penny_release_count", fifo_count, 1);

    // farthing glitch shorter than the debounce window
    do_reset();
    coin_raw[2] = 1'b1;
    repeat (3) tick();
    coin_raw[2] = 1'b0;
    repeat (15) tick();
    check("glitch_count", fifo_count, 0);
    check("glitch_valid", coin_valid, 0);

    // five presses into a four-entry FIFO, then drain
    do_reset();
    press_coin(0);
    press_coin(1);
    press_coin(2);
    press_coin(0);
    check("fill_count", fifo_count, 4);
    check("fill_overflow", overflow, 0);
    press_coin(1);
    check("over_count", fifo_count, 4);
    check("over_overflow", overflow, 1);
    exp_codes[0] = 2'b01;
    exp_codes[1] = 2'b10;
    exp_codes[2] = 2'b11;
    exp_codes[3] = 2'b01;
    coin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), coin_valid, 1);
      check($sformatf("drain_code%0d", i), coin_code, exp_codes[i]);
      tick();
    end
    check("drain_empty_valid", coin_valid, 0);
    check("drain_empty_code", coin_code, 0);
    tick();
    check("drain_ready_ignored", fifo_count, 0);
    coin_ready = 1'b0;
    check("overflow_sticky", overflow, 1);

    // full FIFO with a pop in the same cycle a new press lands
    do_reset();
    press_coin(0);
    press_coin(1);
    press_coin(2);
    press_coin(0);
    coin_raw[2] = 1'b1;
    repeat (7) tick();
    coin_ready = 1'b1;
    tick();
    coin_ready = 1'b0;
    check("fullpop_count", fifo_count, 4);
    check("fullpop_overflow", overflow, 0);
    tick();
    tick();
    coin_raw[2] = 1'b0;
    repeat (8) tick();
    exp_codes[0] = 2'b10;
    exp_codes[1] = 2'b11;
    exp_codes[2] = 2'b01;
    exp_codes[3] = 2'b11;
    coin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fullpop_code%0d", i), coin_code, exp_codes[i]);
      tick();
    end
    coin_ready = 1'b0;
    check("fullpop_empty", coin_valid, 0);

    // penny and ha'penny debounced in the same cycle
    do_reset();
    rej_seen = 0;
    coin_raw = 3'b011;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (reject) rej_seen++;
    end
    coin_raw = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (reject) rej_seen++;
    end
`ifdef COIN_MULTI_REJECT_EN
    check("multi_reject_pulses", rej_seen, 1);
    check("multi_count", fifo_count, 0);
`else
    check("multi_reject_pulses", rej_seen, 0);
    check("multi_code", coin_code, 2'b01);
    check("multi_count", fifo_count, 1);
`endif

    // reset with three coins queued and a channel mid-debounce
    do_reset();
    press_coin(0);
    press_coin(1);
    press_coin(2);
    check("prereset_count", fifo_count, 3);
    coin_raw[0] = 1'b1;
    repeat (4) tick();
    res = 1'b1;
    coin_raw[0] = 1'b0;
    tick();
    check("midreset_valid", coin_valid, 0);
    check("midreset_code", coin_code, 0);
    check("midreset_count", fifo_count, 0);
    check("midreset_overflow", overflow, 0);
    check("midreset_reject", reject, 0);
    res = 1'b0;
    repeat (15) tick();
    check("postreset_count", fifo_count, 0);
    check("postreset_valid", coin_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
